mips_id_ex_stage: RTL and testbench
===================================

Name: mips_id_ex_stage

Overview:
- ID/EX pipeline register for the MIPS datapath, directly upstream of the 32-bit MIPS ALU.
- Captures decoded operands once per clock.
- Translates ALUOp/opcode/funct into the 4-bit ALU control code.
- Selects register or extended-immediate second operand, applies write-back bypass, and supports stall and flush.
- Its registered outputs drive the ALU's ALUctl, A and B inputs with zero added logic in EX.

Parameters:
WIDTH, 32, datapath width of operands
CTL_W, 4, width of ALU control code

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decoded instruction present this cycle
stall  in  1  hold all EX outputs
flush  in  1  replace EX contents with bubble
alu_op  in  2  main-control ALUOp
opcode  in  6  instruction [31:26]
imm16  in  16  instruction [15:0]; funct = imm16[5:0]
rs_addr  in  5  source register A index
rt_addr  in  5  source register B index
rd_addr  in  5  R-type destination
rs_data  in  WIDTH  register-file read port A
rt_data  in  WIDTH  register-file read port B
reg_dst  in  1  1: dest=rd, 0: dest=rt
alu_src  in  1  1: B=extended immediate, 0: B=rt operand
reg_write  in  1  instruction writes a register
wb_we  in  1  write-back port write enable
wb_addr  in  5  write-back register index
wb_data  in  WIDTH  write-back data
ex_valid  out  1  EX slot holds a real instruction
ex_alu_ctl  out  CTL_W  to ALU ALUctl
ex_a  out  WIDTH  to ALU A
ex_b  out  WIDTH  to ALU B
ex_store_data  out  WIDTH  bypassed rt operand (for sw)
ex_dest  out  5  destination register index
ex_reg_write  out  1  write enable travelling to WB
ex_illegal  out  1  unsupported encoding captured

Behaviour:
- All outputs registered.
- Reset (rst_n=0, async) clears every output to 0. ex_alu_ctl=4'b0000.
- Update priority at each rising edge, highest first:
  - reset;
  - flush: ex_valid=0, ex_reg_write=0, ex_illegal=0, all other outputs hold;
  - stall: all outputs hold;
  - capture.
- flush with stall gives a bubble; flush wins.
- Capture with in_valid=0 loads a bubble: ex_valid=0, ex_reg_write=0, ex_illegal=0, data fields hold.
- Capture with in_valid=1 loads every field. Latency is exactly 1 cycle from inputs to ex_* outputs.
- Bypass:
  - op_a = wb_data if wb_we and wb_addr==rs_addr and rs_addr!=0, else rs_data.
  - op_b uses the same rule on rt_addr.
  - Register 0 is never bypassed.
- ex_a=op_a. ex_b=alu_src ? ext_imm : op_b. ex_store_data=op_b.
- ext_imm:
  - zero-extended for opcode 001100 (andi) and 001101 (ori);
  - sign-extended otherwise.
- ex_dest = reg_dst ? rd_addr : rt_addr.
- ALU control decode:
  - alu_op 00 -> 0010 (add: lw/sw)
  - alu_op 01 -> 0110 (sub: beq)
  - alu_op 10, funct:
    - 100000 -> 0010 (add)
    - 100010 -> 0110 (sub)
    - 100100 -> 0000 (and)
    - 100101 -> 0001 (or)
    - 101010 -> 0111 (slt)
    - 100111 -> 1100 (nor)
  - alu_op 11, opcode:
    - 001000 -> 0010 (addi)
    - 001100 -> 0000 (andi)
    - 001101 -> 0001 (ori)
    - 001010 -> 0111 (slti)
- Unlisted funct or opcode:
  - ex_alu_ctl=0010, ex_illegal=1, ex_reg_write forced 0;
  - ex_valid still 1.
- ex_reg_write = reg_write & in_valid & ~illegal.
- Reset asserted mid-stall or mid-flush clears immediately. The first edge after release performs a normal capture.

Test Plan:
- Reset: rst_n=0 asynchronously between edges -> all outputs 0 without a clock edge; release, in_valid=1 R-type add -> outputs update on next edge only.
- R-type sweep: alu_op=10, rs_data=0x0000000F, rt_data=0x00000003, alu_src=0, reg_dst=1, rd=5, for funct add/sub/and/or/slt/nor:
  - ex_alu_ctl=0010/0110/0000/0001/0111/1100 respectively;
  - ex_a=0xF, ex_b=0x3, ex_dest=5, ex_valid=1 one cycle later.
- Immediates: alu_op=11, imm16=0xFFF0:
  - opcode 001000 -> ex_b=0xFFFFFFF0, ctl 0010;
  - opcode 001101 -> ex_b=0x0000FFF0, ctl 0001;
  - reg_dst=0, rt=7 -> ex_dest=7.
- Bypass:
  - wb_we=1, wb_addr=rs_addr=4, wb_data=0xDEADBEEF, rs_data=0 -> ex_a=0xDEADBEEF;
  - repeat with addr 0 -> ex_a=rs_data;
  - rt match with alu_src=1 -> ex_store_data=wb_data, ex_b=imm.
- Stall/flush:
  - capture instruction X, then stall=1 for 3 cycles with changing inputs -> outputs frozen;
  - stall=1 and flush=1 together -> ex_valid=0, ex_reg_write=0, ex_a unchanged.
- Illegal: alu_op=10, funct=001100, reg_write=1 -> ex_illegal=1, ex_alu_ctl=0010, ex_reg_write=0, ex_valid=1; next in_valid=0 -> ex_valid=0, ex_illegal=0.

Source files
------------

// File: rtl/mips_id_ex_stage.sv
// mips_id_ex_stage: ID/EX register (ALU control decode, immediate extend, write-back bypass, stall/flush); drives ALU ctl/A/B plus store data, dest, reg_write, illegal
module mips_id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int CTL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       opcode,
  input  logic [15:0]      imm16,
  input  logic [4:0]       rs_addr,
  input  logic [4:0]       rt_addr,
  input  logic [4:0]       rd_addr,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             reg_dst,
  input  logic             alu_src,
  input  logic             reg_write,
  input  logic             wb_we,
  input  logic [4:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             ex_valid,
  output logic [CTL_W-1:0] ex_alu_ctl,
  output logic [WIDTH-1:0] ex_a,
  output logic [WIDTH-1:0] ex_b,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [4:0]       ex_dest,
  output logic             ex_reg_write,
  output logic             ex_illegal
);
  localparam logic [CTL_W-1:0] C_ADD = CTL_W'(4'b0010);
  localparam logic [CTL_W-1:0] C_SUB = CTL_W'(4'b0110);
  localparam logic [CTL_W-1:0] C_AND = CTL_W'(4'b0000);
  localparam logic [CTL_W-1:0] C_OR  = CTL_W'(4'b0001);
  localparam logic [CTL_W-1:0] C_SLT = CTL_W'(4'b0111);
  localparam logic [CTL_W-1:0] C_NOR = CTL_W'(4'b1100);
  logic [CTL_W-1:0] ctl;
  logic             illegal, load, ctrl_upd;
  logic [WIDTH-1:0] op_a, op_b, ext_imm;
  logic             valid_q, valid_d, reg_write_q, reg_write_d, illegal_q, illegal_d;
  logic [CTL_W-1:0] alu_ctl_q, alu_ctl_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, store_q, store_d;
  logic [4:0]       dest_q, dest_d;
  always_comb begin
    op_a = (wb_we && wb_addr == rs_addr && rs_addr != 5'd0) ? wb_data : rs_data;
    op_b = (wb_we && wb_addr == rt_addr && rt_addr != 5'd0) ? wb_data : rt_data;
    ext_imm = (opcode == 6'b001100 || opcode == 6'b001101) ? {{(WIDTH-16){1'b0}}, imm16}
                                                           : {{(WIDTH-16){imm16[15]}}, imm16};
    ctl = C_ADD;
    illegal = 1'b0;
    case (alu_op)
      2'b00: ctl = C_ADD;
      2'b01: ctl = C_SUB;
      2'b10:
        case (imm16[5:0])
          6'b100000: ctl = C_ADD;
          6'b100010: ctl = C_SUB;
          6'b100100: ctl = C_AND;
          6'b100101: ctl = C_OR;
          6'b101010: ctl = C_SLT;
          6'b100111: ctl = C_NOR;
          default:   illegal = 1'b1;
        endcase
      default:
        case (opcode)
          6'b001000: ctl = C_ADD;
          6'b001100: ctl = C_AND;
          6'b001101: ctl = C_OR;
          6'b001010: ctl = C_SLT;
          default:   illegal = 1'b1;
        endcase
    endcase
    // flush beats stall; a bubble (flush or in_valid=0) clears only the control bits
    load = in_valid && !stall && !flush;
    ctrl_upd = flush || !stall;
    valid_d = ctrl_upd ? load : valid_q;
    illegal_d = ctrl_upd ? (load && illegal) : illegal_q;
    reg_write_d = ctrl_upd ? (load && reg_write && !illegal) : reg_write_q;
    alu_ctl_d = load ? ctl : alu_ctl_q;
    a_d = load ? op_a : a_q;
    b_d = load ? (alu_src ? ext_imm : op_b) : b_q;
    store_d = load ? op_b : store_q;
    dest_d = load ? (reg_dst ? rd_addr : rt_addr) : dest_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      illegal_q <= 1'b0;
      reg_write_q <= 1'b0;
      alu_ctl_q <= '0;
      a_q <= '0;
      b_q <= '0;
      store_q <= '0;
      dest_q <= '0;
    end else begin
      valid_q <= valid_d;
      illegal_q <= illegal_d;
      reg_write_q <= reg_write_d;
      alu_ctl_q <= alu_ctl_d;
      a_q <= a_d;
      b_q <= b_d;
      store_q <= store_d;
      dest_q <= dest_d;
    end
  end
  assign ex_valid = valid_q;
  assign ex_alu_ctl = alu_ctl_q;
  assign ex_a = a_q;
  assign ex_b = b_q;
  assign ex_store_data = store_q;
  assign ex_dest = dest_q;
  assign ex_reg_write = reg_write_q;
  assign ex_illegal = illegal_q;
endmodule

// File: tb/tb_mips_id_ex_stage.sv
// tb_mips_id_ex_stage: directed self-checking bench for mips_id_ex_stage
module tb_mips_id_ex_stage;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 0, stall = 0, flush = 0, reg_dst = 0, alu_src = 0, reg_write = 0, wb_we = 0;
  logic [1:0]  alu_op = 0;
  logic [5:0]  opcode = 0;
  logic [15:0] imm16 = 0;
  logic [4:0]  rs_addr = 0, rt_addr = 0, rd_addr = 0, wb_addr = 0;
  logic [31:0] rs_data = 0, rt_data = 0, wb_data = 0;
  logic        ex_valid, ex_reg_write, ex_illegal;
  logic [3:0]  ex_alu_ctl;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [4:0]  ex_dest;
  int          total = 0, bad = 0;
  logic [5:0]  fn_tab [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
  logic [3:0]  ct_tab [6] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h7, 4'hC};
  mips_id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_op(alu_op), .opcode(opcode), .imm16(imm16), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_addr(rd_addr), .rs_data(rs_data), .rt_data(rt_data), .reg_dst(reg_dst),
    .alu_src(alu_src), .reg_write(reg_write), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .ex_valid(ex_valid), .ex_alu_ctl(ex_alu_ctl), .ex_a(ex_a),
    .ex_b(ex_b), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(ex_valid), 0);
    chk({tag, "_ctl"}, 32'(ex_alu_ctl), 0);
    chk({tag, "_a"}, ex_a, 0);
    chk({tag, "_b"}, ex_b, 0);
    chk({tag, "_st"}, ex_store_data, 0);
    chk({tag, "_dest"}, 32'(ex_dest), 0);
    chk({tag, "_rw"}, 32'(ex_reg_write), 0);
    chk({tag, "_ill"}, 32'(ex_illegal), 0);
  endtask
  initial begin
    step();
    step();
    chk_zero("rst");
    rst_n = 1;
    in_valid = 1; alu_op = 2'b10; imm16 = 16'h0020; rs_addr = 1; rt_addr = 2; rd_addr = 5;
    rs_data = 32'hF; rt_data = 32'h3; reg_dst = 1; reg_write = 1;
    #1;
    chk_zero("pre_edge");
    for (int i = 0; i < 6; i++) begin
      imm16 = {10'd0, fn_tab[i]};
      step();
      chk("r_ctl", 32'(ex_alu_ctl), 32'(ct_tab[i]));
      chk("r_a", ex_a, 32'hF);
      chk("r_b", ex_b, 32'h3);
      chk("r_dest", 32'(ex_dest), 5);
      chk("r_valid", 32'(ex_valid), 1);
      chk("r_rw", 32'(ex_reg_write), 1);
    end
    alu_op = 2'b11; imm16 = 16'hFFF0; alu_src = 1; opcode = 6'b001000;
    step();
    chk("addi_b", ex_b, 32'hFFFFFFF0);
    chk("addi_ctl", 32'(ex_alu_ctl), 2);
    opcode = 6'b001101; reg_dst = 0; rt_addr = 7;
    step();
    chk("ori_b", ex_b, 32'h0000FFF0);
    chk("ori_ctl", 32'(ex_alu_ctl), 1);
    chk("ori_dest", 32'(ex_dest), 7);
    alu_op = 2'b00; alu_src = 0; opcode = 0; wb_we = 1; wb_addr = 4; rs_addr = 4;
    wb_data = 32'hDEADBEEF; rs_data = 0; rt_addr = 2; rt_data = 32'h3;
    step();
    chk("byp_a", ex_a, 32'hDEADBEEF);
    chk("byp_b_nohit", ex_b, 32'h3);
    chk("lw_ctl", 32'(ex_alu_ctl), 2);
    rs_addr = 0; wb_addr = 0; rs_data = 32'h11;
    step();
    chk("byp_r0", ex_a, 32'h11);
    rs_addr = 1; rs_data = 32'h22; rt_addr = 9; wb_addr = 9; alu_src = 1; imm16 = 16'h0005;
    step();
    chk("byp_st", ex_store_data, 32'hDEADBEEF);
    chk("byp_b_imm", ex_b, 32'h5);
    chk("byp_a_nohit", ex_a, 32'h22);
    wb_we = 0; alu_op = 2'b01; alu_src = 0; rs_data = 32'h100; rt_data = 32'h50; rt_addr = 2;
    step();
    chk("beq_ctl", 32'(ex_alu_ctl), 6);
    chk("beq_a", ex_a, 32'h100);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rs_data = 32'(i); alu_op = 2'b10; imm16 = 16'h0024; in_valid = i[0];
      step();
      chk("stl_a", ex_a, 32'h100);
      chk("stl_ctl", 32'(ex_alu_ctl), 6);
      chk("stl_valid", 32'(ex_valid), 1);
    end
    flush = 1; in_valid = 1;
    step();
    chk("sf_valid", 32'(ex_valid), 0);
    chk("sf_rw", 32'(ex_reg_write), 0);
    chk("sf_a", ex_a, 32'h100);
    stall = 0; flush = 0; imm16 = 16'h000C; rs_data = 32'h7;
    step();
    chk("ill", 32'(ex_illegal), 1);
    chk("ill_ctl", 32'(ex_alu_ctl), 2);
    chk("ill_rw", 32'(ex_reg_write), 0);
    chk("ill_valid", 32'(ex_valid), 1);
    chk("ill_a", ex_a, 32'h7);
    in_valid = 0; rs_data = 32'h99;
    step();
    chk("bub_valid", 32'(ex_valid), 0);
    chk("bub_ill", 32'(ex_illegal), 0);
    chk("bub_a", ex_a, 32'h7);
    in_valid = 1; alu_op = 2'b11; opcode = 6'b001111;
    step();
    chk("ill_op", 32'(ex_illegal), 1);
    chk("ill_op_rw", 32'(ex_reg_write), 0);
    opcode = 6'b001010; imm16 = 16'h8000; alu_src = 1;
    step();
    chk("slti_ctl", 32'(ex_alu_ctl), 7);
    chk("slti_b", ex_b, 32'hFFFF8000);
    chk("slti_rw", 32'(ex_reg_write), 1);
    flush = 1; rs_data = 32'h55;
    step();
    chk("fl_valid", 32'(ex_valid), 0);
    chk("fl_a", ex_a, 32'h99);
    flush = 0;
    step();
    stall = 1;
    #2 rst_n = 0;
    #1;
    chk_zero("async");
    stall = 0; alu_op = 2'b10; imm16 = 16'h0025; alu_src = 0; rs_data = 32'hA; rt_data = 32'hB;
    reg_dst = 1; rd_addr = 3;
    #1 rst_n = 1;
    chk("rel_hold", 32'(ex_valid), 0);
    step();
    chk("rel_valid", 32'(ex_valid), 1);
    chk("rel_ctl", 32'(ex_alu_ctl), 1);
    chk("rel_b", ex_b, 32'hB);
    chk("rel_dest", 32'(ex_dest), 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
